// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives an external up/down counter back and forth
// between latched limits lo..hi for a requested number of round trips.
// Optional feature macro: SWEEP_PAUSE_EN adds a pause input that freezes
// the sweep (enable low, state held) while asserted.
module counter_sweep_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    input  logic [3:0] cycles,
    input  logic [7:0] counter_out,
`ifdef SWEEP_PAUSE_EN
    input  logic       pause,
`endif
    output logic       enable,
    output logic       direction,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] sweep_cnt
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEEK = 3'd1,
        UP   = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   lo_r;
    logic [DATA_W-1:0]   hi_r;
    logic [CNT_W-1:0]    cyc_r;
    logic [CNT_W-1:0]    sweep_nxt_c;
    logic                hold_c;

    // Freeze request: only exists when the pause feature is built in
`ifdef SWEEP_PAUSE_EN
    assign hold_c = pause;
`else
    assign hold_c = 1'b0;
`endif

    assign sweep_nxt_c = CNT_W'(sweep_cnt + CNT_W'(1));

    // Sequencer: state, latched parameters, round-trip count and pulse outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            lo_r      <= '0;
            hi_r      <= '0;
            cyc_r     <= '0;
            sweep_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lo_r      <= lo;
                        hi_r      <= hi;
                        cyc_r     <= cycles;
                        sweep_cnt <= '0;
                        if (lo > hi) begin
                            err <= 1'b1;
                        end else if (cycles == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEEK;
                        end
                    end
                end
                SEEK: begin
                    if (!hold_c && counter_out == lo_r) begin
                        state <= UP;
                    end
                end
                UP: begin
                    if (!hold_c && counter_out == hi_r) begin
                        state <= DOWN;
                    end
                end
                DOWN: begin
                    if (!hold_c && counter_out == lo_r) begin
                        sweep_cnt <= sweep_nxt_c;
                        if (sweep_nxt_c == cyc_r) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= UP;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Counter steering: enable drops as soon as the counter sits on its target
    always_comb begin
        enable    = 1'b0;
        direction = 1'b0;
        case (state)
            SEEK: begin
                direction = (counter_out < lo_r);
                enable    = !hold_c && (counter_out != lo_r);
            end
            UP: begin
                direction = 1'b1;
                enable    = !hold_c && (counter_out != hi_r);
            end
            DOWN: begin
                direction = 1'b0;
                enable    = !hold_c && (counter_out != lo_r);
            end
            default: begin
                enable    = 1'b0;
                direction = 1'b0;
            end
        endcase
    end

    // Run-in-progress flag decoded from the state register
    assign busy = (state == SEEK) || (state == UP) || (state == DOWN);

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural up/down counter
// closing the loop on counter_out.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] lo = 8'd0;
    logic [7:0] hi = 8'd0;
    logic [3:0] cycles = 4'd0;
    logic [7:0] cnt = 8'd0;
`ifdef SWEEP_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       enable;
    logic       direction;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweep_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [3:0] cyc;
        logic       en;
        logic       dir;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] sw;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];

    counter_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lo         (lo),
        .hi         (hi),
        .cycles     (cycles),
        .counter_out(cnt),
`ifdef SWEEP_PAUSE_EN
        .pause      (pause),
`endif
        .enable     (enable),
        .direction  (direction),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_cnt  (sweep_cnt)
    );

    always #5 clk = ~clk;

    // External up/down counter
    always @(posedge clk) begin
        if (enable === 1'b1) begin
            cnt <= (direction === 1'b1) ? cnt + 8'd1 : cnt - 8'd1;
        end
    end

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic [7:0] l, input logic [7:0] h,
                                input logic [3:0] c, input logic e, input logic d, input logic b,
                                input logic dn, input logic er, input logic [3:0] sw, input logic [7:0] ct);
        vec_t v;
        v.rst = r; v.start = s; v.lo = l; v.hi = h; v.cyc = c;
        v.en = e; v.dir = d; v.busy = b; v.done = dn; v.err = er; v.sw = sw; v.cnt = ct;
        return v;
    endfunction

    initial begin
        int n;
        // rows: rst,start,lo,hi,cyc | enable,direction,busy,done,err,sweep_cnt,counter
        // reset has priority over start, then start is not replayed
        vq.push_back(mk(0,1,2,5,1, 0,0,0,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
        // basic run lo=2 hi=5 cycles=1 from counter 0
        vq.push_back(mk(1,1,2,5,1, 0,0,0,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,1));
        vq.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,4));
        vq.push_back(mk(1,0,0,0,0, 0,1,1,0,0,0,5));
        vq.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,5));
        vq.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,4));
        vq.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,1,0,1,2));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0,1,2));
        // lo==hi, four round trips with enable low after seek
        vq.push_back(mk(1,1,3,3,4, 0,0,0,0,0,1,2));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 0,1,1,0,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 0,1,1,0,0,1,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,1,0,0,1,3));
        vq.push_back(mk(1,0,0,0,0, 0,1,1,0,0,2,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,1,0,0,2,3));
        vq.push_back(mk(1,0,0,0,0, 0,1,1,0,0,3,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,1,0,0,3,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,1,0,4,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0,4,3));
        // lo>hi: single err pulse, no run
        vq.push_back(mk(1,1,9,4,1, 0,0,0,0,0,4,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,1,0,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,3));
        // cycles==0: straight to done, no enable
        vq.push_back(mk(1,1,1,4,0, 0,0,0,0,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,1,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,3));
        // start with new limits while in DOWN is ignored
        vq.push_back(mk(1,1,2,4,1, 0,0,0,0,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,3));
        vq.push_back(mk(1,0,0,0,0, 0,1,1,0,0,0,4));
        vq.push_back(mk(1,1,0,7,5, 1,0,1,0,0,0,4));
        vq.push_back(mk(1,0,0,7,5, 1,0,1,0,0,0,3));
        vq.push_back(mk(1,0,0,7,5, 0,0,1,0,0,0,2));
        vq.push_back(mk(1,0,0,7,5, 0,0,0,1,0,1,2));
        vq.push_back(mk(1,0,0,7,5, 0,0,0,0,0,1,2));
        // reset during UP at counter 4 with a simultaneous start
        vq.push_back(mk(1,1,2,6,1, 0,0,0,0,0,1,2));
        vq.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0, 1,1,1,0,0,0,3));
        vq.push_back(mk(0,1,2,6,1, 1,1,1,0,0,0,4));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,5));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,5));

        repeat (2) @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; start = vq[i].start;
            lo = vq[i].lo; hi = vq[i].hi; cycles = vq[i].cyc;
            #1;
            chk("enable",    i, 8'(enable),    8'(vq[i].en));
            chk("direction", i, 8'(direction), 8'(vq[i].dir));
            chk("busy",      i, 8'(busy),      8'(vq[i].busy));
            chk("done",      i, 8'(done),      8'(vq[i].done));
            chk("err",       i, 8'(err),       8'(vq[i].err));
            chk("sweep_cnt", i, 8'(sweep_cnt), 8'(vq[i].sw));
            chk("counter",   i, cnt,           vq[i].cnt);
            chk("done_err_excl", i, 8'(done & err), 8'd0);
        end

        // two round trips lo=1 hi=3 from counter 5; done expected 18 cycles after start
        @(negedge clk);
        start = 1'b1; lo = 8'd1; hi = 8'd3; cycles = 4'd2;
        @(negedge clk);
        start = 1'b0; lo = 8'd0; hi = 8'd0; cycles = 4'd0;
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            chk("range", n, 8'(cnt >= 8'd1 && cnt <= 8'd5), 8'd1);
            @(negedge clk);
            n++;
        end
        chk("done_latency", 0, 8'(n), 8'd18);
        chk("done_seen",    0, 8'(done), 8'd1);
        chk("sweep_final",  0, 8'(sweep_cnt), 8'd2);
        chk("cnt_final",    0, cnt, 8'd1);

`ifdef SWEEP_PAUSE_EN
        // pause for 5 cycles during UP, counter must freeze at 2
        @(negedge clk);
        start = 1'b1; lo = 8'd1; hi = 8'd4; cycles = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 5; p++) begin
            if (p > 0) @(negedge clk);
            pause = 1'b1;
            #1;
            chk("pause_enable", p, 8'(enable), 8'd0);
            chk("pause_busy",   p, 8'(busy), 8'd1);
            chk("pause_cnt",    p, cnt, 8'd2);
        end
        @(negedge clk);
        pause = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("pause_done",  0, 8'(done), 8'd1);
        chk("pause_sweep", 0, 8'(sweep_cnt), 8'd1);
        chk("pause_cnt_final", 0, cnt, 8'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
